// File: rtl/hand_coord_uart_tx.sv
// -----------------------------------------------------------------------------
// hand_coord_uart_tx
// Serialises the two hand-marker coordinate pairs to a peer board as a 9-byte
// 8N1 UART packet: three 0xFF sync bytes followed by the clamped top and bottom
// marker coordinates packed as three bytes per pair.
//
// Ports
//   clk_65mhz          : system clock, all logic on this edge
//   sys_rst            : synchronous active-high reset
//   hand_x_left_top    : top marker x (12 bit)
//   hand_y_left_top    : top marker y (12 bit)
//   hand_x_left_bottom : bottom marker x (12 bit)
//   hand_y_left_bottom : bottom marker y (12 bit)
//   transmit_xy_update : one-cycle pulse, coordinates valid this cycle
//   uart_txd           : registered serial output, idle high
//   busy               : high while a packet is being shifted out
//   packet_done        : one-cycle pulse after the final stop bit
//   dropped            : one-cycle pulse when a pending snapshot is overwritten
// -----------------------------------------------------------------------------
module hand_coord_uart_tx #(
    parameter int CLKS_PER_BIT = 564,
    parameter int X_MAX        = 1023,
    parameter int Y_MAX        = 767
) (
    input  logic        clk_65mhz,
    input  logic        sys_rst,
    input  logic [11:0] hand_x_left_top,
    input  logic [11:0] hand_y_left_top,
    input  logic [11:0] hand_x_left_bottom,
    input  logic [11:0] hand_y_left_bottom,
    input  logic        transmit_xy_update,
    output logic        uart_txd,
    output logic        busy,
    output logic        packet_done,
    output logic        dropped
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [3:0]        LAST_BYTE = 4'd8;
    localparam logic [11:0]       X_LIM     = 12'(X_MAX);
    localparam logic [11:0]       Y_LIM     = 12'(Y_MAX);

    // Saturate a coordinate at its ceiling.
    function automatic logic [11:0] clamp12(input logic [11:0] v, input logic [11:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    // Packet byte for a given position. The snapshot is {xt, yt, xb, yb}, so
    // the six payload bytes are simply its consecutive 8-bit slices.
    function automatic logic [7:0] byte_sel(input logic [47:0] snap, input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = 8'hFF;
            4'd1:    b = 8'hFF;
            4'd2:    b = 8'hFF;
            4'd3:    b = snap[47:40];
            4'd4:    b = snap[39:32];
            4'd5:    b = snap[31:24];
            4'd6:    b = snap[23:16];
            4'd7:    b = snap[15:8];
            4'd8:    b = snap[7:0];
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

    logic [1:0]        state_r, state_s;
    logic [2:0]        bit_cnt_r, bit_cnt_s;
    logic [3:0]        byte_cnt_r, byte_cnt_s;
    logic [BAUD_W-1:0] baud_r, baud_s;
    logic              done_s;
    logic              txd_s;
    logic              busy_s;
    logic [7:0]        cur_byte_s;
    logic [47:0]       snap_in_s;
    logic [47:0]       pkt_r;
    logic [47:0]       pend_r;
    logic              pend_valid_r;
    logic              uart_txd_r;
    logic              busy_r;
    logic              packet_done_r;
    logic              dropped_r;

    // Clamped view of the live coordinate inputs.
    always_comb begin
        snap_in_s = {clamp12(hand_x_left_top,    X_LIM), clamp12(hand_y_left_top,    Y_LIM),
                     clamp12(hand_x_left_bottom, X_LIM), clamp12(hand_y_left_bottom, Y_LIM)};
    end

    // Next-state and counter logic of the bit/byte sequencer.
    always_comb begin
        state_s    = state_r;
        bit_cnt_s  = bit_cnt_r;
        byte_cnt_s = byte_cnt_r;
        baud_s     = baud_r;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A fresh update or a parked snapshot both launch a packet.
                if (transmit_xy_update || pend_valid_r) begin
                    state_s    = ST_START;
                    bit_cnt_s  = 3'd0;
                    byte_cnt_s = 4'd0;
                    baud_s     = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_r == BAUD_LAST) begin
                    state_s   = ST_DATA;
                    bit_cnt_s = 3'd0;
                    baud_s    = '0;
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            ST_DATA: begin
                if (baud_r == BAUD_LAST) begin
                    baud_s = '0;
                    if (bit_cnt_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                    end
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            ST_STOP: begin
                if (baud_r == BAUD_LAST) begin
                    baud_s = '0;
                    if (byte_cnt_r == LAST_BYTE) begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                    end else begin
                        state_s    = ST_START;
                        byte_cnt_s = byte_cnt_r + 4'd1;
                    end
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Line level for the next cycle, decoded from the next sequencer state so
    // the output register lines up exactly with the state it belongs to.
    always_comb begin
        cur_byte_s = byte_sel(pkt_r, byte_cnt_s);
        busy_s     = (state_s != ST_IDLE);
        case (state_s)
            ST_IDLE:  txd_s = 1'b1;
            ST_START: txd_s = 1'b0;
            ST_DATA:  txd_s = cur_byte_s[bit_cnt_s];
            ST_STOP:  txd_s = 1'b1;
            default:  txd_s = 1'b1;
        endcase
    end

    // Sequencer state, counters and registered line outputs.
    always_ff @(posedge clk_65mhz) begin
        if (sys_rst) begin
            state_r       <= ST_IDLE;
            bit_cnt_r     <= 3'd0;
            byte_cnt_r    <= 4'd0;
            baud_r        <= '0;
            uart_txd_r    <= 1'b1;
            busy_r        <= 1'b0;
            packet_done_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            bit_cnt_r     <= bit_cnt_s;
            byte_cnt_r    <= byte_cnt_s;
            baud_r        <= baud_s;
            uart_txd_r    <= txd_s;
            busy_r        <= busy_s;
            packet_done_r <= done_s;
        end
    end

    // Snapshot capture: the in-flight packet register only loads in IDLE, so a
    // packet never changes once started; updates while busy park in one slot.
    always_ff @(posedge clk_65mhz) begin
        if (sys_rst) begin
            pkt_r        <= 48'd0;
            pend_r       <= 48'd0;
            pend_valid_r <= 1'b0;
            dropped_r    <= 1'b0;
        end else if (state_r == ST_IDLE) begin
            if (transmit_xy_update) begin
                // The new update supersedes anything still parked.
                pkt_r        <= snap_in_s;
                pend_valid_r <= 1'b0;
                dropped_r    <= pend_valid_r;
            end else if (pend_valid_r) begin
                pkt_r        <= pend_r;
                pend_valid_r <= 1'b0;
                dropped_r    <= 1'b0;
            end else begin
                dropped_r <= 1'b0;
            end
        end else begin
            if (transmit_xy_update) begin
                pend_r       <= snap_in_s;
                pend_valid_r <= 1'b1;
                dropped_r    <= pend_valid_r;
            end else begin
                dropped_r <= 1'b0;
            end
        end
    end

    assign uart_txd    = uart_txd_r;
    assign busy        = busy_r;
    assign packet_done = packet_done_r;
    assign dropped     = dropped_r;

endmodule

// File: tb/tb_hand_coord_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_hand_coord_uart_tx
// Scoreboard bench: stimulus pushes hand-computed packet bytes into a queue, a
// UART decoder process pops and compares every byte it receives, and a monitor
// counts busy, packet_done, dropped and low-line cycles.
// -----------------------------------------------------------------------------
module tb_hand_coord_uart_tx;

    localparam int CPB = 4;

    logic        clk_65mhz;
    logic        sys_rst;
    logic [11:0] hand_x_left_top;
    logic [11:0] hand_y_left_top;
    logic [11:0] hand_x_left_bottom;
    logic [11:0] hand_y_left_bottom;
    logic        transmit_xy_update;
    logic        uart_txd;
    logic        busy;
    logic        packet_done;
    logic        dropped;

    int         n_cmp;
    int         n_err;
    logic [7:0] exp_q[$];
    int         busy_cnt;
    int         done_cnt;
    int         drop_cnt;
    int         low_cnt;

    hand_coord_uart_tx #(.CLKS_PER_BIT(CPB), .X_MAX(1023), .Y_MAX(767)) dut (
        .clk_65mhz          (clk_65mhz),
        .sys_rst            (sys_rst),
        .hand_x_left_top    (hand_x_left_top),
        .hand_y_left_top    (hand_y_left_top),
        .hand_x_left_bottom (hand_x_left_bottom),
        .hand_y_left_bottom (hand_y_left_bottom),
        .transmit_xy_update (transmit_xy_update),
        .uart_txd           (uart_txd),
        .busy               (busy),
        .packet_done        (packet_done),
        .dropped            (dropped)
    );

    // Free-running clock.
    initial begin
        clk_65mhz = 1'b0;
        forever #5 clk_65mhz = ~clk_65mhz;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Queue the nine expected bytes of a packet, first byte in the top slice.
    task automatic push9(input logic [71:0] b);
        for (int i = 8; i >= 0; i--) begin
            exp_q.push_back(b[i*8 +: 8]);
        end
    endtask

    // One-cycle update pulse; returns just after the edge that samples it.
    task automatic pulse(input logic [11:0] xt, input logic [11:0] yt,
                         input logic [11:0] xb, input logic [11:0] yb);
        @(posedge clk_65mhz);
        #1;
        hand_x_left_top    = xt;
        hand_y_left_top    = yt;
        hand_x_left_bottom = xb;
        hand_y_left_bottom = yb;
        transmit_xy_update = 1'b1;
        @(posedge clk_65mhz);
        #1;
        transmit_xy_update = 1'b0;
    endtask

    // Wait (bounded) for packet_done; returns on the negedge it is seen.
    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk_65mhz);
            if (packet_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            check({name, "_done_busy"}, {31'd0, busy}, 32'd0);
        end
    endtask

    // Next packet must start on the cycle right after packet_done.
    task automatic check_b2b(input string name);
        @(negedge clk_65mhz);
        check({name, "_b2b_txd"},  {31'd0, uart_txd}, 32'd0);
        check({name, "_b2b_busy"}, {31'd0, busy},     32'd1);
    endtask

    // Activity monitor: counts per-cycle output levels.
    initial begin
        busy_cnt = 0;
        done_cnt = 0;
        drop_cnt = 0;
        low_cnt  = 0;
        forever begin
            @(negedge clk_65mhz);
            if (busy === 1'b1)        busy_cnt++;
            if (packet_done === 1'b1) done_cnt++;
            if (dropped === 1'b1)     drop_cnt++;
            if (uart_txd === 1'b0)    low_cnt++;
        end
    end

    // UART decoder: samples every cycle, checks 4-cycle bit cells, pops and
    // compares each received byte against the scoreboard queue.
    initial begin : decoder
        logic [39:0] smp;
        logic        ok;
        logic        aborted;
        logic [7:0]  got;
        forever begin
            @(negedge clk_65mhz);
            if (sys_rst !== 1'b1 && uart_txd === 1'b0) begin
                smp     = '0;
                aborted = 1'b0;
                for (int i = 1; i < 40; i++) begin
                    @(negedge clk_65mhz);
                    if (sys_rst === 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    smp[i] = uart_txd;
                end
                if (!aborted) begin
                    ok = 1'b1;
                    for (int k = 0; k < 10; k++) begin
                        for (int j = 1; j < CPB; j++) begin
                            if (smp[k*CPB + j] !== smp[k*CPB]) ok = 1'b0;
                        end
                    end
                    check("bit_timing", {31'd0, ok}, 32'd1);
                    check("stop_bit", {31'd0, smp[39]}, 32'd1);
                    for (int b = 0; b < 8; b++) begin
                        got[b] = smp[(b + 1) * CPB];
                    end
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_byte: got %02h, expected no byte", got);
                    end else begin
                        check("rx_byte", {24'd0, got}, {24'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    // Directed stimulus.
    initial begin : stim
        int b0, d0, x0, l0;
        n_cmp = 0;
        n_err = 0;
        sys_rst            = 1'b1;
        transmit_xy_update = 1'b0;
        hand_x_left_top    = 12'd0;
        hand_y_left_top    = 12'd0;
        hand_x_left_bottom = 12'd0;
        hand_y_left_bottom = 12'd0;
        repeat (3) @(posedge clk_65mhz);
        #1;
        sys_rst = 1'b0;

        // Reset state and idle line.
        @(negedge clk_65mhz);
        check("rst_txd",     {31'd0, uart_txd},    32'd1);
        check("rst_busy",    {31'd0, busy},        32'd0);
        check("rst_done",    {31'd0, packet_done}, 32'd0);
        check("rst_dropped", {31'd0, dropped},     32'd0);
        l0 = low_cnt;
        repeat (10) @(posedge clk_65mhz);
        #1;
        check("idle_high", low_cnt - l0, 32'd0);

        // Single packet.
        b0 = busy_cnt;
        d0 = done_cnt;
        push9(72'hFFFFFF_123045_2A01FF);
        pulse(12'h123, 12'h045, 12'h2A0, 12'h1FF);
        @(negedge clk_65mhz);
        check("start_txd",  {31'd0, uart_txd}, 32'd0);
        check("start_busy", {31'd0, busy},     32'd1);
        wait_done("single");
        @(posedge clk_65mhz);
        #1;
        check("busy_cycles", busy_cnt - b0, 32'd360);
        repeat (20) @(posedge clk_65mhz);
        #1;
        check("single_done_count", done_cnt - d0, 32'd1);
        check("single_queue_empty", exp_q.size(), 32'd0);

        // Clamped coordinates.
        push9(72'hFFFFFF_3FF2FF_3FF2FF);
        pulse(12'hFFF, 12'h900, 12'h400, 12'h300);
        wait_done("clamp");
        repeat (5) @(posedge clk_65mhz);

        // Update queued during a packet goes out back to back.
        x0 = drop_cnt;
        push9(72'hFFFFFF_001002_003004);
        pulse(12'h001, 12'h002, 12'h003, 12'h004);
        repeat (98) @(posedge clk_65mhz);
        push9(72'hFFFFFF_3AB2CD_0EF101);
        pulse(12'h3AB, 12'h2CD, 12'h0EF, 12'h101);
        wait_done("queued_a");
        check_b2b("queued");
        wait_done("queued_b");
        @(posedge clk_65mhz);
        #1;
        check("queued_no_drop", drop_cnt - x0, 32'd0);
        repeat (5) @(posedge clk_65mhz);

        // Three updates in one packet: middle one overwritten, one drop.
        x0 = drop_cnt;
        push9(72'hFFFFFF_111222_333044);
        pulse(12'h111, 12'h222, 12'h333, 12'h044);
        repeat (40) @(posedge clk_65mhz);
        pulse(12'h0AA, 12'h0BB, 12'h0CC, 12'h0DD);
        repeat (40) @(posedge clk_65mhz);
        push9(72'hFFFFFF_2F010F_00C2D3);
        pulse(12'h2F0, 12'h10F, 12'h00C, 12'h2D3);
        wait_done("ovw_a");
        check_b2b("ovw");
        wait_done("ovw_b");
        @(posedge clk_65mhz);
        #1;
        check("ovw_drop_count", drop_cnt - x0, 32'd1);
        repeat (5) @(posedge clk_65mhz);

        // Reset mid-packet with a snapshot pending: abort and stay idle.
        push9(72'hFFFFFF_555666_777088);
        pulse(12'h555, 12'h666, 12'h777, 12'h088);
        repeat (58) @(posedge clk_65mhz);
        pulse(12'h0AB, 12'h0CD, 12'h0EF, 12'h012);
        repeat (88) @(posedge clk_65mhz);
        #1;
        sys_rst = 1'b1;
        exp_q.delete();
        @(posedge clk_65mhz);
        #1;
        sys_rst = 1'b0;
        d0 = done_cnt;
        l0 = low_cnt;
        @(negedge clk_65mhz);
        check("midrst_txd",  {31'd0, uart_txd}, 32'd1);
        check("midrst_busy", {31'd0, busy},     32'd0);
        repeat (300) @(posedge clk_65mhz);
        #1;
        check("midrst_no_done", done_cnt - d0, 32'd0);
        check("midrst_idle",    low_cnt - l0,  32'd0);

        // Reset wins over a simultaneous update.
        @(posedge clk_65mhz);
        #1;
        sys_rst            = 1'b1;
        transmit_xy_update = 1'b1;
        @(posedge clk_65mhz);
        #1;
        sys_rst            = 1'b0;
        transmit_xy_update = 1'b0;
        l0 = low_cnt;
        @(negedge clk_65mhz);
        check("prio_txd",  {31'd0, uart_txd}, 32'd1);
        check("prio_busy", {31'd0, busy},     32'd0);
        repeat (50) @(posedge clk_65mhz);
        #1;
        check("prio_idle", low_cnt - l0, 32'd0);

        // Normal operation after reset.
        push9(72'hFFFFFF_0F000F_3FF2FF);
        pulse(12'h0F0, 12'h00F, 12'h3FF, 12'h2FF);
        wait_done("recover");
        repeat (10) @(posedge clk_65mhz);
        #1;
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hand_coord_uart_tx.md
HAND_COORD_UART_TX -- requirements
Module: hand_coord_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 564, meaning clk_65mhz cycles per UART bit (65 MHz / 115200 baud).
REQ-002 SHALL have parameter X_MAX, default 1023, meaning the clamp ceiling for x coordinates.
REQ-003 SHALL have parameter Y_MAX, default 767, meaning the clamp ceiling for y coordinates.
REQ-004 SHALL have port clk_65mhz  input  1  system clock; the block has one clock and all logic is on it.
REQ-005 SHALL have port sys_rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port hand_x_left_top  input  12  top marker x.
REQ-007 SHALL have port hand_y_left_top  input  12  top marker y.
REQ-008 SHALL have port hand_x_left_bottom  input  12  bottom marker x.
REQ-009 SHALL have port hand_y_left_bottom  input  12  bottom marker y.
REQ-010 SHALL have port transmit_xy_update  input  1  single-cycle pulse: coordinates valid this cycle.
REQ-011 SHALL have port uart_txd  output  1  serial line to the peer board (jc[0]), idle high.
REQ-012 SHALL have port busy  output  1  high while a packet is being shifted out.
REQ-013 SHALL have port packet_done  output  1  one-cycle pulse after a packet's final stop bit.
REQ-014 SHALL have port dropped  output  1  one-cycle pulse when a pending snapshot is overwritten.

Function
REQ-015 SHALL snapshot all four coordinates on every cycle transmit_xy_update=1, clamping x to X_MAX and y to Y_MAX.
REQ-016 SHALL form a 9-byte packet, in send order: FF, FF, FF, xt[11:4], {xt[3:0],yt[11:8]}, yt[7:0], xb[11:4], {xb[3:0],yb[11:8]}, yb[7:0], where xt/yt/xb/yb are the clamped snapshot values.
REQ-017 SHALL send each byte as 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each bit held exactly CLKS_PER_BIT cycles.
REQ-018 SHALL send the bytes back to back with no idle gap; one packet lasts exactly 90*CLKS_PER_BIT cycles.
REQ-019 SHALL implement the states IDLE, START, DATA, STOP, with an internal bit counter 0..7, byte counter 0..8, and baud counter 0..CLKS_PER_BIT-1.
REQ-020 SHALL make these transitions: IDLE->START when a snapshot is available; START->DATA after one bit time; DATA->STOP after eight bit times; STOP->START if byte<8, otherwise STOP->IDLE.
REQ-021 SHALL, when transmit_xy_update=1 in IDLE at cycle N, drive uart_txd=0 and busy=1 from cycle N+1.
REQ-022 SHALL hold an update arriving while busy as a single pending snapshot; a later update while pending SHALL overwrite it (latest wins) and pulse dropped.
REQ-023 SHALL assert packet_done for exactly one cycle on the cycle after the last stop bit ends, with busy=0 in that cycle.
REQ-024 SHALL, if a snapshot is pending at packet_done, start its start bit on the cycle after packet_done.
REQ-025 SHALL treat an update in the packet_done cycle as arriving in IDLE (REQ-021).
REQ-026 SHALL never change the in-flight packet contents once its first start bit begins.
REQ-027 SHALL register uart_txd with no combinational path from any input.

Reset
REQ-028 SHALL, with sys_rst=1, on the next edge set the state to IDLE, clear all counters and the pending flag, and set uart_txd=1, busy=0, packet_done=0, dropped=0.
REQ-029 SHALL, on reset mid-packet, abort immediately and never resume the aborted packet.
REQ-030 SHALL have sys_rst take priority over transmit_xy_update in the same cycle.

Verification (bench uses CLKS_PER_BIT=4)
REQ-031 Single packet: xt=0x123, yt=0x045, xb=0x2A0, yb=0x1FF, one pulse -> bytes FF FF FF 12 30 45 2A 01 FF decoded; busy high for 360 cycles; one packet_done.
REQ-032 Clamp: xt=0xFFF, yt=0x900 -> bytes 3F F2 FF in positions 4-6, so no FFFFFF sequence appears after the header.
REQ-033 Queued update: second pulse at cycle 100 of a packet -> second packet starts its start bit exactly one cycle after packet_done, with the second snapshot's data.
REQ-034 Overwrite: three pulses during one packet -> one dropped pulse; the next packet carries the third pulse's data.
REQ-035 Reset mid-packet: sys_rst at cycle 150 -> uart_txd=1 and busy=0 the next cycle; no packet_done; line stays idle until a new pulse.
REQ-036 Bit timing: every bit measured at exactly 4 cycles; the line idles high before the first pulse.
